// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: DEPTH slots with valid/ready backpressure,
// bubble collapsing and synchronous flush. Define PIPE_STAGE_REG_DATA_CLR_EN to reset/clear data.
module pipe_stage_reg #(
    parameter int DATA_W = 71,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  occupancy_o
);

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_d;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic [DEPTH-1:0]  rdy_s;
    logic              rdy_acc_s;
    logic [DEPTH:0]    chain_v_s;
    logic [DATA_W-1:0] chain_d_s [DEPTH+1];
    logic [CNT_W-1:0]  occ_s;

    // Ready chain: a slot may load when it, or any slot downstream of it, is free
    always_comb begin
        rdy_acc_s = out_ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_acc_s = rdy_acc_s | ~v_q[k];
            rdy_s[k]  = rdy_acc_s;
        end
    end

    assign in_ready_o = rdy_s[0] & ~flush_i;

    // Predecessor view: entry k feeds slot k, entry DEPTH is the output slot itself
    always_comb begin
        chain_v_s    = {v_q, in_valid_i};
        chain_d_s[0] = in_data_i;
        for (int k = 0; k < DEPTH; k++) begin
            chain_d_s[k+1] = d_q[k];
        end
    end

    // Next-state valid bits; flush wins over any load
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_i) begin
                v_d[k] = 1'b0;
            end else if (rdy_s[k]) begin
                v_d[k] = chain_v_s[k];
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Next-state data words
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
`ifdef PIPE_STAGE_REG_DATA_CLR_EN
            if (flush_i) begin
                d_d[k] = {DATA_W{1'b0}};
            end else if (rdy_s[k]) begin
                d_d[k] = chain_v_s[k] ? chain_d_s[k] : {DATA_W{1'b0}};
            end else begin
                d_d[k] = d_q[k];
            end
`else
            // Data only moves with a valid word, saving toggles on bubbles
            if (rdy_s[k] && chain_v_s[k]) begin
                d_d[k] = chain_d_s[k];
            end else begin
                d_d[k] = d_q[k];
            end
`endif
        end
    end

    // Valid bit register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= {DEPTH{1'b0}};
        end else begin
            v_q <= v_d;
        end
    end

`ifdef PIPE_STAGE_REG_DATA_CLR_EN
    // Data register with reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            d_q <= d_d;
        end
    end
`else
    // Data register without reset
    always_ff @(posedge clk_i) begin
        d_q <= d_d;
    end
`endif

    // Occupancy is a popcount of the registered valid bits
    always_comb begin
        occ_s = {CNT_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            occ_s = occ_s + CNT_W'(chain_v_s[k+1]);
        end
    end

    assign occupancy_o = occ_s;
    assign out_valid_o = chain_v_s[DEPTH];
    assign out_data_o  = chain_d_s[DEPTH];

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor to the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed control/data word through `DEPTH` register slots, with per-slot valid bits, valid/ready backpressure for stalls, bubble collapsing and a synchronous flush. It sits between any two pipeline stages. The hazard unit drives `flush_i` and `out_ready_i`.

## Interface
- `DATA_W`, default 71: width of the packed stage word (control, data, destination register fields).
- `DEPTH`, default 1: number of register slots, legal range 1..8.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width. Derived; do not override.

Ports:
- `clk_i`, input, 1: single clock, rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `flush_i`, input, 1: synchronous flush that kills every slot.
- `in_valid_i`, input, 1: upstream word valid.
- `in_ready_o`, output, 1: this block can accept a word this cycle.
- `in_data_i`, input, `DATA_W`: upstream word.
- `out_valid_o`, output, 1: slot `DEPTH-1` holds a valid word.
- `out_ready_i`, input, 1: downstream accepts the word this cycle.
- `out_data_o`, output, `DATA_W`: data of slot `DEPTH-1`.
- `occupancy_o`, output, `CNT_W`: number of valid slots.

## Operation
- Slots are numbered 0..`DEPTH-1`. Slot 0 takes input; slot `DEPTH-1` drives the output. Each slot holds `v[k]` and `d[k]`.
- Ready chain (combinational):
  - `rdy[DEPTH-1] = !v[DEPTH-1] | out_ready_i`
  - `rdy[k] = !v[k] | rdy[k+1]`
  - `in_ready_o = rdy[0] & !flush_i`
- Each edge, when `rdy[k]` is 1, slot k loads from its predecessor:
  - slot 0 loads `in_valid_i`/`in_data_i`;
  - slot k>0 loads `v[k-1]`/`d[k-1]`.
- When `rdy[k]` is 0, the slot holds (stall).
- Bubbles collapse: an empty slot always loads, even while downstream is stalled.
- Transfers:
  - Input transfer: `in_valid_i & in_ready_o`.
  - Output transfer: `out_valid_o & out_ready_i`.
- Loading an invalid predecessor clears `v[k]`. Data then loads per `Configuration`.
- Flush has priority over everything. At the next edge all `v[k]` are 0 and no input is accepted.
  - An output transfer in the flush cycle still counts as completed downstream.
- `occupancy_o` is the popcount of `v[]`, combinational from registers only.
- `out_valid_o` equals `v[DEPTH-1]`; `out_data_o` equals `d[DEPTH-1]`. Both come straight from registers, with no combinational path from inputs.
- Protocol assumptions on the environment:
  - `in_data_i` is stable while `in_valid_i & !in_ready_o`.
  - `in_valid_i` is not withdrawn while stalled.
- `DEPTH=1` with `out_ready_i=1` and `flush_i=0` behaves as a plain enabled register.

## Timing
- Reset (async assert, released synchronously by the environment) forces:
  - all `v[k]` = 0;
  - `out_valid_o` = 0;
  - `occupancy_o` = 0;
  - `out_data_o` = 0 when `PIPE_STAGE_REG_DATA_CLR_EN` is defined, otherwise unknown/don't-care.
- Reset mid-stream discards all slots. `in_ready_o` is 1 immediately after reset while `flush_i`=0.
- Latency: a word accepted at edge n appears on `out_valid_o`/`out_data_o` after edge n+`DEPTH-1`, i.e. `DEPTH` cycles from presentation, when never stalled.
- Throughput: one word per cycle while `out_ready_i`=1.
- Full (all `v`=1, `out_ready_i`=0): `in_ready_o`=0 and all slots hold.
- Full with `out_ready_i`=1: simultaneous input and output transfer occur, and occupancy is unchanged.
- Combinational path from `out_ready_i` to `in_ready_o` spans `DEPTH` gates. This is accepted for `DEPTH`≤8.

## Configuration
- `PIPE_STAGE_REG_DATA_CLR_EN` defined:
  - `d[k]` resets to 0;
  - `d[k]` is cleared to 0 on flush, and whenever the slot loads an invalid word;
  - `out_data_o` is 0 whenever `out_valid_o`=0.
- Undefined: `d[k]` has no reset and no clear, and loads only when the loaded valid is 1. This saves area and power. `out_data_o` is don't-care while `out_valid_o`=0.

## Test plan
- Reset and stream: `DEPTH=3`, `DATA_W=71`, `out_ready_i`=1, words 0x1..0x5 on consecutive cycles. Required: 0x1 appears 3 cycles after presentation, then one word per cycle, and `occupancy_o` peaks at 3.
- Backpressure fill: `DEPTH=3`, `out_ready_i`=0, push 0xA, 0xB, 0xC, 0xD. Required: `in_ready_o` drops after the 3rd acceptance, 0xD is held upstream, and `occupancy_o`=3. Then raise `out_ready_i`: output is 0xA, 0xB, 0xC, 0xD in order with no loss or duplicate.
- Bubble collapse: `DEPTH=4`, push 0x11, idle 2 cycles, push 0x22, with `out_ready_i`=0. Required: both words compact into slots 3 and 2, `occupancy_o`=2, and `in_ready_o` stays 1.
- Flush: `DEPTH=2` full with 0x5/0x6, assert `flush_i` together with `in_valid_i`=1. Required:
  - `in_ready_o`=0 in that cycle;
  - next cycle `out_valid_o`=0 and `occupancy_o`=0;
  - with `PIPE_STAGE_REG_DATA_CLR_EN`, `out_data_o`=0.
- Async reset mid-stream: `DEPTH=2` with 2 valid words, pulse `rst_i` between edges. Required: `out_valid_o`=0 immediately (before the next edge), and the first word pushed after release emerges 2 cycles later.
- Full pass-through: `DEPTH=1`, full, `out_ready_i`=1, `in_valid_i`=1 continuously. Required: one transfer each side per cycle, and `occupancy_o` stays 1.
